sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Parametrised serial-in/parallel-out deserializer for the register library: accepts LANES bits per beat on a valid/ready stream and assembles them into WIDTH-bit words. Supports MSB-first or LSB-first ordering per word, flushing a partial word with zero padding, and a one-word output holding register so a new word can be shifted in while the previous one awaits acceptance. Sits between a serial link front end and word-wide consumers.

## Interface
- WIDTH, 8, output word width in bits; must be ≥2 and a multiple of LANES.
- LANES, 1, bits accepted per beat; 1 ≤ LANES ≤ WIDTH.
- Derived localparams: BEATS = WIDTH/LANES; CW = $clog2(BEATS+1).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- msb_first  in  1  1 = first beat lands in the MSBs (shift left); 0 = first beat lands in the LSBs (shift right). Sampled on the first beat of each word.
- in_valid  in  1  beat present on in_data.
- in_data  in  LANES  beat payload. In LSB-first mode in_data[0] is the earlier bit; in MSB-first mode in_data[LANES-1] is the earlier bit.
- flush  in  1  close the current partial word; held until accepted.
- in_ready  out  1  beat and/or flush accepted this cycle when asserted.
- out_valid  out  1  out_data/out_beats hold a word.
- out_data  out  WIDTH  assembled word.
- out_beats  out  CW  number of real beats in out_data (1..BEATS).
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.

## Operation
- State: shift register sr[WIDTH-1:0], beat counter cnt (0..BEATS-1), word-mode register mode, and output register (out_data, out_beats, out_valid).
- A beat is accepted when in_valid && in_ready.
  - When cnt==0, the beat captures msb_first into mode. Changes to msb_first mid-word are ignored.
  - mode=1: sr ← {sr[WIDTH-LANES-1:0], in_data}.
  - mode=0: sr ← {in_data, sr[WIDTH-1:LANES]}.
- Completion of a word occurs on either event below; sr and cnt are then cleared.
  - A beat accepted with cnt==BEATS-1 completes a full word: out_data = shifted value, out_beats = BEATS, out_valid = 1.
  - A flush accepted with n beats held (n = cnt after any same-cycle beat, n > 0) completes a partial word. The word is padded as if BEATS−n zero beats followed: mode=1 gives sr << (BEATS−n)·LANES; mode=0 gives sr >> (BEATS−n)·LANES. out_beats = n.
- Flush accepted with n == 0 is a no-op and emits no word. Flush in the same cycle as a completing beat emits only the full word.
- in_ready = !out_valid || out_ready || (cnt != BEATS-1 && !flush). This is a combinational path from out_ready to in_ready, by design, to give full throughput.
- out_valid clears on out_valid && out_ready, unless a new word loads in the same cycle, in which case it stays 1 with the new contents.
- out_data and out_beats are stable while out_valid && !out_ready.

## Timing
- Latency: the completing beat at edge k gives out_valid=1 with the word after edge k.
- Sustained throughput is one beat per cycle, including LANES==WIDTH (one word per cycle) while out_ready=1.
- Backpressure: when out_valid && !out_ready and the next beat would complete a word (or a flush is pending), in_ready=0. Non-completing beats are still accepted.
- Reset (any time, including mid-word or with a word pending) gives: sr=0, cnt=0, mode=1, out_valid=0, out_data=0, out_beats=0. Partial and pending words are discarded. in_ready=1 in the cycle after reset.
- rst has priority over every other input.

## Structure
- Single module; no sub-module required.
- BEATS and CW are local to the module; no shared-package content needed.
- Elaboration-time checks: WIDTH % LANES == 0 and WIDTH ≥ 2. Fatal on violation.
- One always block for sr/cnt/mode, one for the output register. in_ready is continuous.

## Test plan
- WIDTH=8, LANES=1, msb_first=1, serial 1,0,1,1,0,0,1,0 with out_ready=1 → one word 8'hB2, out_beats=8, out_valid for exactly one cycle after the 8th beat.
- Same bits with msb_first=0 → 8'h4D. Toggling msb_first after beat 3 does not change the result.
- WIDTH=8, LANES=2, msb_first=1, beats 2'b11,2'b01 then flush → 8'hD0, out_beats=2. Flush with cnt=0 → no word.
- out_ready=0 while a word is pending; feed 7 beats of the next word → all accepted; 8th beat sees in_ready=0. Raise out_ready → first word accepted, 8th beat accepted the same cycle, second word valid next cycle.
- WIDTH=LANES=8, out_ready=1, in_valid continuous with 8'h01, 8'h02, 8'h03 → words on three consecutive cycles, in_ready stays 1.
- rst asserted after 5 beats with a word pending → all outputs zero next cycle. A fresh 8-beat stream then yields a correct word with no residue from before reset.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// sipo_deserializer_pkg : shared word-ordering type for the deserializer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sipo_deserializer_pkg;

  typedef enum logic {
    MODE_LSB_FIRST = 1'b0,
    MODE_MSB_FIRST = 1'b1
  } word_mode_e;

  localparam word_mode_e MODE_RESET = MODE_MSB_FIRST;

endpackage : sipo_deserializer_pkg

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer : LANES-bit beats in, WIDTH-bit words out, flush + hold reg
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 msb_first,
  input  logic                                 in_valid,
  input  logic [LANES-1:0]                     in_data,
  input  logic                                 flush,
  output logic                                 in_ready,
  output logic                                 out_valid,
  output logic [WIDTH-1:0]                     out_data,
  output logic [$clog2((WIDTH/LANES)+1)-1:0]   out_beats,
  input  logic                                 out_ready
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_BEATS = CW'(BEATS);

  generate
    if ((WIDTH % LANES) != 0 || WIDTH < 2 || LANES < 1) begin : g_param_check
      $fatal(1, "sipo_deserializer: WIDTH must be >= 2 and a multiple of LANES");
    end
  endgenerate

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  word_mode_e       mode_q, mode_d;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_beats_q, out_beats_d;
  logic             out_valid_q, out_valid_d;

  logic             w_beat;
  logic             w_flush;
  word_mode_e       w_mode;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_padded;
  logic [CW-1:0]    w_held;
  logic [31:0]      w_pad_bits;
  logic             w_full;
  logic             w_partial;

  // out_ready feeds in_ready combinationally so a completing beat can land
  // in the same cycle the held word is taken.
  assign in_ready = !out_valid_q || out_ready || ((cnt_q != LAST_BEAT) && !flush);
  assign w_beat   = in_valid && in_ready;
  assign w_flush  = flush && in_ready;

  always_comb begin
    w_mode = (cnt_q == '0) ? word_mode_e'(msb_first) : mode_q;

    if (w_mode == MODE_MSB_FIRST) begin
      w_shifted = (sr_q << LANES) | WIDTH'(in_data);
    end else begin
      w_shifted = (sr_q >> LANES) | (WIDTH'(in_data) << (WIDTH - LANES));
    end

    w_held    = w_beat ? (cnt_q + CW'(1)) : cnt_q;
    w_full    = w_beat && (cnt_q == LAST_BEAT);
    w_partial = w_flush && !w_full && (w_held != '0);

    // Padding behaves as though the missing beats were zeros shifted in.
    w_src      = w_beat ? w_shifted : sr_q;
    w_pad_bits = 32'((BEATS - int'(w_held)) * LANES);
    if (w_mode == MODE_MSB_FIRST) begin
      w_padded = w_src << w_pad_bits;
    end else begin
      w_padded = w_src >> w_pad_bits;
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (w_beat) begin
      sr_d   = w_shifted;
      cnt_d  = w_held;
      mode_d = w_mode;
    end
    if (w_full || w_partial) begin
      sr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_RESET;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_full) begin
      out_data_d  = w_shifted;
      out_beats_d = FULL_BEATS;
      out_valid_d = 1'b1;
    end else if (w_partial) begin
      out_data_d  = w_padded;
      out_beats_d = w_held;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

endmodule : sipo_deserializer

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deserializer : checks three lane configurations of the deserializer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deserializer;

  localparam int NCFG = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [NCFG];
  logic       fl   [NCFG];
  logic       ordy [NCFG];
  logic       msb  [NCFG];
  logic [7:0] id   [NCFG];
  wire        ir   [NCFG];
  wire        ov   [NCFG];
  wire  [7:0] od   [NCFG];
  wire  [7:0] ob   [NCFG];

  int vecs = 0;
  int errs = 0;

  // reference model: beats of the word being assembled plus the held word
  int         q[$];
  bit         m_mode;
  bit         m_ov;
  logic [7:0] m_od;
  logic [7:0] m_ob;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < NCFG; k++) begin : g_dut
      localparam int L  = (k == 0) ? 1 : (k == 1) ? 2 : 8;
      localparam int CW = $clog2((8 / L) + 1);
      wire [CW-1:0] beats_w;
      sipo_deserializer #(.WIDTH(8), .LANES(L)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .msb_first (msb[k]),
        .in_valid  (iv[k]),
        .in_data   (id[k][L-1:0]),
        .flush     (fl[k]),
        .in_ready  (ir[k]),
        .out_valid (ov[k]),
        .out_data  (od[k]),
        .out_beats (beats_w),
        .out_ready (ordy[k])
      );
      assign ob[k] = 8'(beats_w);
    end
  endgenerate

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 8;
  endfunction

  // Beat i sits in slot (BEATS-1-i) for MSB-first, slot i for LSB-first;
  // missing trailing beats are simply absent (zero).
  function automatic logic [7:0] build(input int k, input int b[$], input bit mode);
    int L;
    int B;
    int w;
    L = lanes_of(k);
    B = 8 / L;
    w = 0;
    for (int i = 0; i < b.size(); i++) begin
      w = w | (b[i] << (mode ? (B - 1 - i) * L : i * L));
    end
    return 8'(w);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k, input bit v, input logic [7:0] d, input bit f,
                     input bit r, input bit m);
    int  L;
    int  B;
    bit  exp_ir;
    bit  beat;
    bit  flsh;
    bit  full;
    L = lanes_of(k);
    B = 8 / L;
    @(negedge clk);
    iv[k]   = v;
    id[k]   = d;
    fl[k]   = f;
    ordy[k] = r;
    msb[k]  = m;
    #1;
    exp_ir = !m_ov || r || ((q.size() != B - 1) && !f);
    chk("in_ready", 8'(ir[k]), 8'(exp_ir));
    chk("out_valid", 8'(ov[k]), 8'(m_ov));
    if (m_ov) begin
      chk("out_data", od[k], m_od);
      chk("out_beats", ob[k], m_ob);
    end
    beat = v && exp_ir;
    flsh = f && exp_ir;
    full = 1'b0;
    if (beat) begin
      if (q.size() == 0) m_mode = m;
      q.push_back(int'(d) & ((1 << L) - 1));
      full = (q.size() == B);
    end
    if (m_ov && r) m_ov = 1'b0;
    if (full || (flsh && q.size() > 0)) begin
      m_ov = 1'b1;
      m_od = build(k, q, m_mode);
      m_ob = 8'(q.size());
      q.delete();
    end
  endtask

  task automatic idle(input int k, input bit r);
    cyc(k, 1'b0, 8'h00, 1'b0, r, 1'b1);
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst     = 1'b1;
    iv[k]   = 1'b1;
    fl[k]   = 1'b1;
    ordy[k] = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    iv[k]   = 1'b0;
    fl[k]   = 1'b0;
    ordy[k] = 1'b1;
    #1;
    chk("rst_out_valid", 8'(ov[k]), 8'h00);
    chk("rst_out_data", od[k], 8'h00);
    chk("rst_out_beats", ob[k], 8'h00);
    chk("rst_in_ready", 8'(ir[k]), 8'h01);
    q.delete();
    m_mode = 1'b1;
    m_ov   = 1'b0;
    m_od   = 8'h00;
    m_ob   = 8'h00;
  endtask

  task automatic random_run(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(k, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom));
    end
    for (int i = 0; i < 3; i++) idle(k, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bits;
    rst = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1; msb[k] = 1'b1; id[k] = 8'h00;
    end

    // LANES=1: MSB-first, LSB-first with mid-word mode toggle
    do_reset(0);
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 8'(bits[7-i]), 1'b0, 1'b1, 1'b1);
    idle(0, 1'b1);
    chk("word_B2", od[0], 8'hB2);
    idle(0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 8'(bits[7-i]), 1'b0, 1'b1, i >= 3);
    idle(0, 1'b1);
    chk("word_4D", od[0], 8'h4D);
    idle(0, 1'b1);

    // backpressure: one word held, next word stalls on its final beat
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("bp_stall", 8'(ir[0]), 8'h00);
    cyc(0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    idle(0, 1'b0);
    idle(0, 1'b1);
    idle(0, 1'b1);

    // reset with a word pending and a partial word in flight
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    do_reset(0);
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    idle(0, 1'b1);
    idle(0, 1'b1);
    random_run(0, 200);

    // LANES=2: flush padding, empty flush, flush alongside a first beat
    do_reset(1);
    cyc(1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
    cyc(1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    cyc(1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("flush_D0", od[1], 8'hD0);
    chk("flush_beats", ob[1], 8'h02);
    cyc(1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("empty_flush", 8'(ov[1]), 8'h00);
    cyc(1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    random_run(1, 200);

    // LANES=WIDTH: one word per cycle
    do_reset(2);
    for (int i = 1; i <= 3; i++) cyc(2, 1'b1, 8'(i), 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("wide_last", od[2], 8'h03);
    idle(2, 1'b1);
    random_run(2, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_sipo_deserializer

`default_nettype wire
